button_conditioner: RTL

// - Upstream front end for the game controller: turns raw, bouncy, asynchronous push-button inputs
//   (hit, stay, ...) into clean, clk-synchronous debounced levels and single-cycle press pulses.
// - Sits between the board pins and main_controller. Each btn_pulse bit drives one hit/stay

---
 rtl/btn_cond_pkg.sv | 25 ++
 rtl/button_conditioner_if.sv | 32 +++
 rtl/btn_debounce_ch.sv | 109 ++++++++++
 rtl/button_conditioner.sv | 75 +++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and helpers for the push-button conditioner: channel FSM
// state encoding and the debounce counter width.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PRESSED = 2'd2,
    REL     = 2'd3
  } btn_state_t;

  localparam int STATE_W = 2;

  // Counter width for a given stability window; the counter only ever
  // reaches debounce_cycles-1, so $clog2 is enough (minimum one bit).
  function automatic int cnt_w(input int debounce_cycles);
    int w;
    w = $clog2(debounce_cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Pin-side bundle of the button conditioner: raw buttons in, debounced
// levels, press strobes, drop strobe and per-channel FSM state out.
interface button_conditioner_if #(
  parameter int N_BTN = 2
);
  import btn_cond_pkg::*;

  // No valid/ready here: btn_pulse and btn_drop are single-cycle strobes
  // that the consumer must sample every clock; there is no backpressure.
  logic [N_BTN-1:0]         btn_raw;
  logic [N_BTN-1:0]         btn_level;
  logic [N_BTN-1:0]         btn_pulse;
  logic                     btn_drop;
  logic [STATE_W*N_BTN-1:0] dbg_state;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  btn_drop,
    input  dbg_state
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output btn_drop,
    output dbg_state
  );

endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, IDLE/ARM/PRESSED/REL debounce
// FSM with a stability counter, registered level and a raw press event.
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  output logic       level,
  output logic       press_evt,
  output btn_state_t state_dbg
);

  localparam int               CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  logic [1:0]    sync_q;
  logic          s;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_d;

  // Metastability guard: only the second flop is ever looked at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  assign s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // A change is accepted only after DEBOUNCE_CYCLES consecutive synced
  // samples disagree with the current level; any agreeing sample restarts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = ARM;
          cnt_d   = CNT_ONE;
        end
      end
      ARM: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = REL;
          cnt_d   = CNT_ONE;
        end
      end
      REL: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // press_evt is combinational so the top can register it on the same
  // edge that level rises.
  assign level     = level_q;
  assign press_evt = press_d;
  assign state_dbg = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Button front end: one debounce channel per button plus a registered
// priority stage that turns press events into (optionally one-hot) pulses.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit ONE_HOT_PULSE   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  logic [N_BTN-1:0]         level_vec;
  logic [N_BTN-1:0]         evt_vec;
  logic [STATE_W*N_BTN-1:0] dbg_vec;
  logic [N_BTN-1:0]         pulse_d, pulse_q;
  logic                     drop_d, drop_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_state_t st;

    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw      (bus.btn_raw[i]),
      .level    (level_vec[i]),
      .press_evt(evt_vec[i]),
      .state_dbg(st)
    );

    assign dbg_vec[STATE_W*i +: STATE_W] = st;
  end

  // Lowest index wins; simultaneous losers are discarded, not queued.
  always_comb begin
    logic taken;
    pulse_d = '0;
    drop_d  = 1'b0;
    taken   = 1'b0;
    if (ONE_HOT_PULSE) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (evt_vec[i]) begin
          if (!taken) begin
            pulse_d[i] = 1'b1;
            taken      = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
    end else begin
      pulse_d = evt_vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.btn_level = level_vec;
  assign bus.btn_pulse = pulse_q;
  assign bus.btn_drop  = drop_q;
  assign bus.dbg_state = dbg_vec;

endmodule
